// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM encoding, parameter
// defaults and the value returned to a data read that was aborted.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY_IF = 3'd1,
    ST_BUSY_DM = 3'd2,
    ST_RESP_IF = 3'd3,
    ST_RESP_DM = 3'd4
  } arb_state_e;

  localparam int MAX_STARVE_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  localparam logic [31:0] ABORT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at LIMIT.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign at_limit = (cnt_q == WIDTH'(LIMIT));

  // Clear wins over increment so a grant/leave in the same cycle restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access.
// DM has fixed priority; IF is guaranteed a grant after MAX_STARVE losses.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = MAX_STARVE_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          if_stall,
  output logic          dm_stall,
  output logic          timeout_err
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic          timeout_err_q, timeout_err_d;

  logic          starve_inc, starve_clr, starve_at_limit;
  logic          tcnt_inc, tcnt_clr, tcnt_at_limit;

  sat_counter #(
    .WIDTH (SW),
    .LIMIT (MAX_STARVE)
  ) u_starve_cnt (
    .clk      (Clk),
    .rst_n    (Rst),
    .clr      (starve_clr),
    .inc      (starve_inc),
    .at_limit (starve_at_limit)
  );

  sat_counter #(
    .WIDTH (TW),
    .LIMIT (TIMEOUT - 1)
  ) u_tcnt (
    .clk      (Clk),
    .rst_n    (Rst),
    .clr      (tcnt_clr),
    .inc      (tcnt_inc),
    .at_limit (tcnt_at_limit)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_ready_d    = 1'b0;
    dm_ready_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    starve_inc    = 1'b0;
    starve_clr    = 1'b0;
    tcnt_inc      = 1'b0;
    tcnt_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // DM wins unless IF has already lost MAX_STARVE times in a row.
        if (dm_req && !(if_req && starve_at_limit)) begin
          state_d     = ST_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          starve_inc  = if_req;
        end else if (if_req) begin
          state_d    = ST_BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_clr = 1'b1;
        end
      end

      ST_BUSY_IF: begin
        if (mem_ack) begin
          state_d    = ST_RESP_IF;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          tcnt_clr   = 1'b1;
        end else if (tcnt_at_limit) begin
          state_d       = ST_RESP_IF;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          if_ready_d    = 1'b1;
          tcnt_clr      = 1'b1;
        end else begin
          tcnt_inc = 1'b1;
        end
      end

      ST_BUSY_DM: begin
        if (mem_ack) begin
          state_d    = ST_RESP_DM;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          tcnt_clr   = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (tcnt_at_limit) begin
          state_d       = ST_RESP_DM;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          dm_ready_d    = 1'b1;
          tcnt_clr      = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = DW'(ABORT_RDATA);
          end
        end else begin
          tcnt_inc = 1'b1;
        end
      end

      ST_RESP_IF, ST_RESP_DM: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_ready_q    <= 1'b0;
      dm_ready_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_ready_q    <= if_ready_d;
      dm_ready_q    <= dm_ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ready    = if_ready_q;
  assign dm_ready    = dm_ready_q;
  assign timeout_err = timeout_err_q;
  assign if_stall    = if_req & ~if_ready_q;
  assign dm_stall    = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: reset, latency, priority, starvation,
// timeout, wait states and stray acknowledges.
module tb_unified_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        if_stall;
  logic        dm_stall;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  unified_mem_arbiter #(
    .AW(32), .DW(32), .MAX_STARVE(4), .TIMEOUT(16)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .if_stall(if_stall), .dm_stall(dm_stall), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; mem_rdata = 0; mem_ack = 0;
    tick(); tick();
    vectors++;
    if ({mem_req, mem_we, if_ready, dm_ready, timeout_err, if_stall, dm_stall} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0000000",
        {mem_req, mem_we, if_ready, dm_ready, timeout_err, if_stall, dm_stall});
    end
    vectors++;
    if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {if_rdata, dm_rdata, mem_addr, mem_wdata});
    end
    Rst = 1'b1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL rst_busy_dm: got req=%b addr=%h want req=1 addr=20", mem_req, mem_addr);
    end
    Rst = 1'b0;
    tick();
    vectors++;
    if (mem_req !== 1'b0 || dm_ready !== 1'b0 || mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL rst_midflight: got req=%b rdy=%b addr=%h want 0 0 0", mem_req, dm_ready, mem_addr);
    end
    Rst = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL rst_regrant: got req=%b addr=%h want req=1 addr=20", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h1234;
    tick();
    vectors++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'h1234 || if_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_dm_read: got rdy=%b data=%h want rdy=1 data=1234", dm_ready, dm_rdata);
    end
    mem_ack = 0; dm_req = 0;
    tick();
  endtask

  task automatic test_if_zero_wait();
    if_req = 1; if_addr = 32'h10;
    #1;
    vectors++;
    if (if_stall !== 1'b1) begin
      miscompares++; $display("FAIL if_stall_t: got %b want 1", if_stall);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_stall !== 1'b1) begin
      miscompares++; $display("FAIL if_busy: got req=%b addr=%h we=%b stall=%b want 1 10 0 1",
        mem_req, mem_addr, mem_we, if_stall);
    end
    mem_ack = 1; mem_rdata = 32'h8C01_0004;
    tick();
    vectors++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h8C01_0004 || if_stall !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++; $display("FAIL if_resp: got rdy=%b data=%h stall=%b req=%b want 1 8c010004 0 0",
        if_ready, if_rdata, if_stall, mem_req);
    end
    if_req = 0; mem_ack = 0;
    tick();
    vectors++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h8C01_0004) begin
      miscompares++; $display("FAIL if_hold: got rdy=%b data=%h want 0 8c010004", if_ready, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h80;
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h55;
    tick();
    vectors++;
    if (mem_addr !== 32'h40 || mem_we !== 1'b1 || mem_wdata !== 32'h55) begin
      miscompares++; $display("FAIL sim_dm_first: got addr=%h we=%b wd=%h want 40 1 55", mem_addr, mem_we, mem_wdata);
    end
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== 32'h1234) begin
      miscompares++; $display("FAIL sim_dm_write: got rdy=%b ifrdy=%b data=%h want 1 0 1234", dm_ready, if_ready, dm_rdata);
    end
    mem_ack = 0; dm_req = 0; dm_we = 0;
    tick();
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      miscompares++; $display("FAIL sim_if_next: got req=%b addr=%h we=%b want 1 80 0", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1; mem_rdata = 32'h0000_A5A5;
    tick();
    vectors++;
    if (if_ready !== 1'b1 || dm_ready !== 1'b0 || if_rdata !== 32'h0000_A5A5) begin
      miscompares++; $display("FAIL sim_if_resp: got rdy=%b dmrdy=%b data=%h want 1 0 a5a5", if_ready, dm_ready, if_rdata);
    end
    mem_ack = 0; if_req = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h100};
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr[g]) begin
        miscompares++; $display("FAIL starve_grant%0d: got req=%b addr=%h want 1 %h", g, mem_req, mem_addr, exp_addr[g]);
      end
      mem_ack = 1; mem_rdata = 32'hC0DE_0000 + g;
      tick();
      vectors++;
      if ({if_ready, dm_ready} !== ((exp_addr[g] == 32'h200) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL starve_ready%0d: got if/dm=%b%b", g, if_ready, dm_ready);
      end
      mem_ack = 0;
      tick();
    end
    dm_req = 0; if_req = 0;
    vectors++;
    if (dm_rdata !== 32'hC0DE_0005 || if_rdata !== 32'hC0DE_0004) begin
      miscompares++; $display("FAIL starve_data: got dm=%h if=%h want c0de0005 c0de0004", dm_rdata, if_rdata);
    end
  endtask

  task automatic test_timeout();
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_ack = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (mem_req !== 1'b1 || timeout_err !== 1'b0 || dm_ready !== 1'b0) begin
        miscompares++; $display("FAIL tmo_busy%0d: got req=%b err=%b rdy=%b want 1 0 0", i, mem_req, timeout_err, dm_ready);
      end
      tick();
    end
    vectors++;
    if (mem_req !== 1'b0 || dm_ready !== 1'b1 || dm_rdata !== 32'h0 || timeout_err !== 1'b1) begin
      miscompares++; $display("FAIL tmo_abort: got req=%b rdy=%b data=%h err=%b want 0 1 0 1",
        mem_req, dm_ready, dm_rdata, timeout_err);
    end
    dm_req = 0;
    tick();
    vectors++;
    if (timeout_err !== 1'b1 || dm_ready !== 1'b0) begin
      miscompares++; $display("FAIL tmo_sticky: got err=%b rdy=%b want 1 0", timeout_err, dm_ready);
    end
  endtask

  task automatic test_wait_states();
    if_req = 1; if_addr = 32'h44;
    tick();
    for (int w = 0; w < 3; w++) begin
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h44 || if_ready !== 1'b0) begin
        miscompares++; $display("FAIL wait%0d: got req=%b addr=%h rdy=%b want 1 44 0", w, mem_req, mem_addr, if_ready);
      end
      if (w == 1) if_addr = 32'h99;
      tick();
    end
    mem_ack = 1; mem_rdata = 32'h77;
    vectors++;
    if (mem_addr !== 32'h44) begin
      miscompares++; $display("FAIL wait_ack_addr: got %h want 44", mem_addr);
    end
    tick();
    vectors++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h77 || mem_req !== 1'b0) begin
      miscompares++; $display("FAIL wait_resp: got rdy=%b data=%h req=%b want 1 77 0", if_ready, if_rdata, mem_req);
    end
    mem_ack = 0; if_req = 0;
    tick();
    vectors++;
    if (if_ready !== 1'b0) begin
      miscompares++; $display("FAIL wait_one_pulse: got rdy=%b want 0", if_ready);
    end
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    for (int s = 0; s < 2; s++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0 || if_rdata !== 32'h77 || dm_rdata !== 32'h0) begin
        miscompares++; $display("FAIL stray_ack%0d: got req=%b ifr=%b dmr=%b ifd=%h dmd=%h want 0 0 0 77 0",
          s, mem_req, if_ready, dm_ready, if_rdata, dm_rdata);
      end
    end
    mem_ack = 0;
  endtask

  task automatic test_reset_clears_err();
    Rst = 1'b0;
    tick();
    vectors++;
    if (timeout_err !== 1'b0 || if_rdata !== 32'h0) begin
      miscompares++; $display("FAIL err_reset: got err=%b ifd=%h want 0 0", timeout_err, if_rdata);
    end
    Rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_if_zero_wait();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_wait_states();
    test_reset_clears_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
